// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the RV32I fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // addi x0, x0, 0 -- presented on instr_o whenever no valid word is offered
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One prefetch buffer entry: the fetched word together with its PC
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Bundle of imem, redirect and decode handshake signals for
//                the fetch unit. master = fetch unit, slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output pc_o,
        output pc_plus4_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  pc_o,
        input  pc_plus4_o
    );

endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Prefetch FIFO of fetch_entry_t with push, pop and flush.
//                No bypass: a pushed entry is visible the cycle after push.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_pop;

    // Never pop past empty, even if the caller misbehaves
    assign w_do_pop = i_pop && (r_count != '0);

    // Storage, pointers and occupancy; flush discards everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I instruction fetch front end. Owns the fetch PC, issues
//                one request per cycle to a 1-cycle-latency imem under a
//                credit limit, buffers responses in a prefetch FIFO and hands
//                them to decode over valid/ready. A redirect from execute
//                flushes all fetched-but-unconsumed work.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] c_DEPTH = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_outstanding;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Credit uses registered state only so a same-cycle pop never frees a slot
    assign w_outstanding = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue       = !rst && !bus.redirect_i && (w_outstanding < c_DEPTH);

    // A response arriving alongside a redirect belongs to the old path
    assign w_push        = r_inflight && !bus.redirect_i;
    assign w_push_entry  = '{pc: r_req_pc, instr: bus.imem_rdata_i};

    assign w_valid       = (w_count != '0) && !bus.redirect_i;
    assign w_pop         = w_valid && bus.instr_ready_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_i),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Fetch PC, PC of the outstanding request, and inflight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC & ~32'd3;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (bus.redirect_i) begin
            r_fetch_pc <= bus.redirect_pc_i & ~32'd3;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_inflight <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    assign bus.imem_req_o    = w_issue;
    assign bus.imem_addr_o   = r_fetch_pc;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = w_valid ? w_head.instr : NOP_INSTR;
    assign bus.pc_o          = w_head.pc;
    assign bus.pc_plus4_o    = w_head.pc + 32'd4;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. The imem model
//                returns (address ^ KEY) one cycle after each request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fetch_if bus ();

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 1-cycle-latency synchronous instruction memory
    always @(posedge clk) begin
        if (bus.imem_req_o) bus.imem_rdata_i <= bus.imem_addr_o ^ KEY;
    end

    task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
        bus.instr_ready_i = rdy;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.imem_req_o); end
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.instr_valid_o); end
        total++; if (bus.instr_o !== NOP_INSTR) begin bad++; $display("FAIL reset_instr got=%h want=%h", bus.instr_o, NOP_INSTR); end
        total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", bus.pc_o); end
        total++; if (bus.pc_plus4_o !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h want=4", bus.pc_plus4_o); end
    endtask

    task automatic test_stream();
        logic [31:0] ep;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            drive(1'b1, 1'b0, 32'h0);
            total++; if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL stream_req c=%0d got=%b want=1", c, bus.imem_req_o); end
            total++; if (bus.imem_addr_o !== 32'(4 * c)) begin bad++; $display("FAIL stream_addr c=%0d got=%h want=%h", c, bus.imem_addr_o, 32'(4 * c)); end
            total++; if (bus.instr_valid_o !== (c >= 2)) begin bad++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, bus.instr_valid_o, (c >= 2)); end
            if (c >= 2) begin
                ep = 32'(4 * (c - 2));
                total++; if (bus.pc_o !== ep) begin bad++; $display("FAIL stream_pc c=%0d got=%h want=%h", c, bus.pc_o, ep); end
                total++; if (bus.instr_o !== (ep ^ KEY)) begin bad++; $display("FAIL stream_instr c=%0d got=%h want=%h", c, bus.instr_o, ep ^ KEY); end
                total++; if (bus.pc_plus4_o !== ep + 32'd4) begin bad++; $display("FAIL stream_pc4 c=%0d got=%h want=%h", c, bus.pc_plus4_o, ep + 32'd4); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic        ereq;
        logic [31:0] ea;
        logic [31:0] ep;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            if (c != 0) @(negedge clk);
            drive(c >= 7, 1'b0, 32'h0);
            ereq = (c < 4) || (c >= 8);
            ea   = (c < 4) ? 32'(4 * c) : 32'(32'h10 + 4 * (c - 8));
            ep   = (c < 7) ? 32'h0 : 32'(4 * (c - 7));
            total++; if (bus.imem_req_o !== ereq) begin bad++; $display("FAIL bp_req c=%0d got=%b want=%b", c, bus.imem_req_o, ereq); end
            if (ereq) begin
                total++; if (bus.imem_addr_o !== ea) begin bad++; $display("FAIL bp_addr c=%0d got=%h want=%h", c, bus.imem_addr_o, ea); end
            end
            total++; if (bus.instr_valid_o !== (c >= 2)) begin bad++; $display("FAIL bp_valid c=%0d got=%b want=%b", c, bus.instr_valid_o, (c >= 2)); end
            if (c >= 2) begin
                total++; if (bus.pc_o !== ep) begin bad++; $display("FAIL bp_pc c=%0d got=%h want=%h", c, bus.pc_o, ep); end
                total++; if (bus.instr_o !== (ep ^ KEY)) begin bad++; $display("FAIL bp_instr c=%0d got=%h want=%h", c, bus.instr_o, ep ^ KEY); end
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] ep;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            drive(1'b0, 1'b0, 32'h0);
        end
        // FIFO now holds 3 entries with a fourth request in flight
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h100);
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL redir_valid_t got=%b want=0", bus.instr_valid_o); end
        total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL redir_req_t got=%b want=0", bus.imem_req_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0);
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin bad++; $display("FAIL redir_req_t1 got=%b/%h want=1/00000100", bus.imem_req_o, bus.imem_addr_o); end
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL redir_valid_t1 got=%b want=0", bus.instr_valid_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0);
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL redir_valid_t2 got=%b want=0", bus.instr_valid_o); end
        total++; if (bus.imem_addr_o !== 32'h104) begin bad++; $display("FAIL redir_addr_t2 got=%h want=00000104", bus.imem_addr_o); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h0);
            ep = 32'(32'h100 + 4 * c);
            total++; if (bus.instr_valid_o !== 1'b1) begin bad++; $display("FAIL redir_valid_new c=%0d got=%b want=1", c, bus.instr_valid_o); end
            total++; if (bus.pc_o !== ep || bus.instr_o !== (ep ^ KEY)) begin bad++; $display("FAIL redir_new c=%0d got=%h/%h want=%h/%h", c, bus.pc_o, bus.instr_o, ep, ep ^ KEY); end
        end
    endtask

    task automatic test_align_wrap();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c != 0) @(negedge clk);
            drive(1'b1, 1'b0, 32'h0);
        end
        @(negedge clk); drive(1'b1, 1'b1, 32'h103);
        total++; if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL align_t got=%b/%b want=0/0", bus.imem_req_o, bus.instr_valid_o); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.imem_addr_o !== 32'h100) begin bad++; $display("FAIL align_addr got=%h want=00000100", bus.imem_addr_o); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.imem_addr_o !== 32'h104) begin bad++; $display("FAIL align_next got=%h want=00000104", bus.imem_addr_o); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h100) begin bad++; $display("FAIL align_out got=%b/%h want=1/00000100", bus.instr_valid_o, bus.pc_o); end
        @(negedge clk); drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h want=fffffffc", bus.imem_addr_o); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_next got=%b/%h want=1/00000000", bus.imem_req_o, bus.imem_addr_o); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.pc_o !== 32'hFFFF_FFFC || bus.pc_plus4_o !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h/%h want=fffffffc/00000000", bus.pc_o, bus.pc_plus4_o); end
        total++; if (bus.instr_o !== (32'hFFFF_FFFC ^ KEY)) begin bad++; $display("FAIL wrap_instr got=%h want=%h", bus.instr_o, 32'hFFFF_FFFC ^ KEY); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.pc_o !== 32'h0 || bus.pc_plus4_o !== 32'h4) begin bad++; $display("FAIL wrap_after got=%h/%h want=0/4", bus.pc_o, bus.pc_plus4_o); end
        // Back-to-back redirects: the later target wins
        @(negedge clk); drive(1'b1, 1'b1, 32'h200);
        @(negedge clk); drive(1'b1, 1'b1, 32'h300);
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h300) begin bad++; $display("FAIL dbl_redir got=%b/%h want=1/00000300", bus.imem_req_o, bus.imem_addr_o); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h300) begin bad++; $display("FAIL dbl_redir_out got=%b/%h want=1/00000300", bus.instr_valid_o, bus.pc_o); end
    endtask

    task automatic test_random_ready();
        logic [31:0] ep = 32'h0;
        int          issued = 0;
        int          popped = 0;
        int          errs   = 0;
        logic        r;
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            if (c != 0) @(negedge clk);
            r = 1'($urandom_range(0, 1));
            drive(r, 1'b0, 32'h0);
            if (c >= 2) begin
                total++; if (bus.instr_valid_o !== 1'b1) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_gap c=%0d got=%b want=1", c, bus.instr_valid_o); end
            end
            if (bus.instr_valid_o === 1'b1) begin
                total++; if (bus.pc_o !== ep || bus.instr_o !== (ep ^ KEY)) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_pc c=%0d got=%h/%h want=%h/%h", c, bus.pc_o, bus.instr_o, ep, ep ^ KEY); end
            end
            if (bus.imem_req_o === 1'b1) begin
                total++; if (bus.imem_addr_o !== 32'(4 * issued)) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_addr c=%0d got=%h want=%h", c, bus.imem_addr_o, 32'(4 * issued)); end
                issued++;
            end
            total++; if (issued - popped > 4) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_occupancy c=%0d got=%0d want<=4", c, issued - popped); end
            if (bus.instr_valid_o === 1'b1 && r) begin
                popped++;
                ep = ep + 32'd4;
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c != 0) @(negedge clk);
            drive(1'b1, 1'b0, 32'h0);
        end
        total++; if (bus.pc_o !== 32'hC) begin bad++; $display("FAIL arst_pre got=%h want=0000000c", bus.pc_o); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL arst_now got=%b/%b want=0/0", bus.instr_valid_o, bus.imem_req_o); end
        total++; if (bus.instr_o !== NOP_INSTR) begin bad++; $display("FAIL arst_instr got=%h want=%h", bus.instr_o, NOP_INSTR); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL arst_restart got=%b/%h want=1/00000000", bus.imem_req_o, bus.imem_addr_o); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.imem_addr_o !== 32'h4 || bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL arst_c1 got=%h/%b want=00000004/0", bus.imem_addr_o, bus.instr_valid_o); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h0);
        total++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h0) begin bad++; $display("FAIL arst_c2 got=%b/%h want=1/00000000", bus.instr_valid_o, bus.pc_o); end
    endtask

    initial begin
        bus.instr_ready_i = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_align_wrap();
        test_random_ready();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
